// File: rtl/mux_rr_nto1_pkg.sv
// Shared types and reset constants for the round-robin N:1 mux.
// Optional feature macro: MUX_PKT_LOCK_EN (packet lock). Nothing here depends on N or WIDTH.
package mux_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam logic        OUT_VALID_RST = 1'b0;
  localparam logic        OUT_LAST_RST  = 1'b0;
  localparam lock_state_t LOCK_RST      = UNLOCKED;

endpackage

// File: rtl/mux_rr_nto1_if.sv
// Handshake bundle for mux_rr_nto1: N producer channels in, one consumer out.
// The slave modport is the mux side; the master modport drives producers/consumer.
// With MUX_PKT_LOCK_EN defined the bundle also carries in_last/out_last.
interface mux_rr_nto1_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic [N-1:0]       in_last;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/mux_rr_nto1_rr_arbiter.sv
// Round-robin arbiter over N requesters; owns last_grant and, with
// MUX_PKT_LOCK_EN defined, the packet lock state.
//
// Lock FSM (MUX_PKT_LOCK_EN only):
//   state    | meaning
//   UNLOCKED | plain round-robin, search starts at last_grant+1
//   LOCKED   | mid-packet; only channel last_grant may be granted
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
`ifdef MUX_PKT_LOCK_EN
  input  logic            lock_hold,
`endif
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

  logic [SELW-1:0] last_grant;
  logic            locked;

  // Pointer moves only on an actual transfer, so a stalled grant keeps its turn.
  always_ff @(posedge clk) begin
    if (rst) last_grant <= LAST_RST;
    else if (advance) last_grant <= grant_idx;
  end

`ifdef MUX_PKT_LOCK_EN
  lock_state_t lock_q, lock_d;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) lock_q <= LOCK_RST;
    else lock_q <= lock_d;
  end

  // Each transferred beat decides the lock: a non-final beat locks, a final beat releases.
  always_comb begin
    lock_d = lock_q;
    if (advance) lock_d = lock_hold ? LOCKED : UNLOCKED;
  end

  assign locked = (lock_q == LOCKED);
`else
  assign locked = 1'b0;
`endif

  // Grant selection: locked channel only, else first requester after last_grant.
  always_comb begin
    logic            found;
    int              idx;
    logic [SELW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    if (locked) begin
      if (req[last_grant]) begin
        grant[last_grant] = 1'b1;
        grant_idx         = last_grant;
      end
    end else begin
      for (int off = 1; off <= N; off++) begin
        idx = int'(last_grant) + off;
        if (idx >= N) idx = idx - N;
        cand = SELW'(idx);
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 registered multiplexer with per-channel valid/ready and round-robin arbitration.
// Output register captures one granted word per cycle with its source index.
// Define MUX_PKT_LOCK_EN to keep a multi-beat packet on one channel until in_last.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  mux_rr_nto1_if.slave   bus
);

  logic                 load;
  logic                 advance;
  logic [N-1:0]         grant;
  logic [SELW-1:0]      grant_idx;
  logic [WIDTH-1:0]     word_sel;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SELW-1:0]      out_sel_q;

  // Register is free when empty or being popped this cycle; nothing is accepted during reset.
  assign load         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (load && !rst) ? grant : '0;
  assign advance      = |(bus.in_valid & bus.in_ready);

`ifdef MUX_PKT_LOCK_EN
  logic lock_hold;
  logic out_last_q;

  assign lock_hold = |(grant & ~bus.in_last);
`endif

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.in_valid),
    .advance   (advance),
`ifdef MUX_PKT_LOCK_EN
    .lock_hold (lock_hold),
`endif
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot data select driven only by grant, so in_data never reaches an output combinationally.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) word_sel = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: capture on transfer, drain when free with no requester, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= OUT_VALID_RST;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word_sel;
      out_sel_q   <= grant_idx;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Registered copy of the accepted beat's end-of-packet flag.
  always_ff @(posedge clk) begin
    if (rst) out_last_q <= OUT_LAST_RST;
    else if (advance) out_last_q <= !lock_hold;
  end

  assign bus.out_last = out_last_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
